// File: rtl/dvi_tmds_encoder_pkg.sv
// Shared constants, pixel payload and helpers for the three-channel DVI TMDS encoder.
package dvi_tmds_encoder_pkg;

    localparam int unsigned SYM_W   = 10;
    localparam int unsigned DATA_W  = 8;
    localparam int unsigned COLOR_W = 4;
    localparam int unsigned QM_W    = DATA_W + 1;
    localparam int unsigned ONES_W  = 4;
    localparam int unsigned CNT_W   = 5;

    localparam logic [SYM_W-1:0] TOKEN_00 = 10'b1101010100;
    localparam logic [SYM_W-1:0] TOKEN_01 = 10'b0010101011;
    localparam logic [SYM_W-1:0] TOKEN_10 = 10'b0101010100;
    localparam logic [SYM_W-1:0] TOKEN_11 = 10'b1010101011;

    typedef struct packed {
        logic              de;
        logic              hsync;
        logic              vsync;
        logic [DATA_W-1:0] red;
        logic [DATA_W-1:0] green;
        logic [DATA_W-1:0] blue;
    } pixel_t;

    function automatic logic [ONES_W-1:0] count_ones(input logic [DATA_W-1:0] d);
        logic [ONES_W-1:0] sum;
        sum = '0;
        for (int i = 0; i < DATA_W; i++) begin
            sum = sum + ONES_W'(d[i]);
        end
        return sum;
    endfunction

    function automatic logic [SYM_W-1:0] ctrl_token(input logic c1, input logic c0);
        logic [SYM_W-1:0] tok;
        case ({c1, c0})
            2'b00:   tok = TOKEN_00;
            2'b01:   tok = TOKEN_01;
            2'b10:   tok = TOKEN_10;
            default: tok = TOKEN_11;
        endcase
        return tok;
    endfunction

endpackage

// File: rtl/dvi_tmds_encoder_channel.sv
// One TMDS lane: transition minimisation (stage 2) and DC balancing / control tokens (stage 3).
module tmds_channel
    import dvi_tmds_encoder_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] data,
    input  logic              de,
    input  logic              c1,
    input  logic              c0,
    output logic [SYM_W-1:0]  symbol
);

    logic [ONES_W-1:0] n1_data;
    logic              use_xnor;
    logic [QM_W-1:0]   q_m_c;
    logic              acc;

    logic [QM_W-1:0]   q_m;
    logic [ONES_W-1:0] n1_q;
    logic [ONES_W-1:0] n0_q;
    logic              de_q;
    logic              c1_q;
    logic              c0_q;

    logic [CNT_W-1:0]        cnt;
    logic [CNT_W-1:0]        cnt_d;
    logic [SYM_W-1:0]        sym_d;
    logic signed [CNT_W:0]   cnt_ext;
    logic signed [CNT_W:0]   bal;
    logic signed [CNT_W:0]   cnt_sum;
    logic                    cnt_zero;
    logic                    cnt_neg;
    logic                    cnt_pos;

    // Stage 2 combinational: XOR/XNOR chain choosing whichever gives fewer transitions
    always_comb begin
        n1_data  = count_ones(data);
        use_xnor = (n1_data > 4'd4) || ((n1_data == 4'd4) && !data[0]);
        q_m_c    = '0;
        acc      = data[0];
        q_m_c[0] = data[0];
        for (int i = 1; i < DATA_W; i++) begin
            acc      = use_xnor ? ~(acc ^ data[i]) : (acc ^ data[i]);
            q_m_c[i] = acc;
        end
        q_m_c[QM_W-1] = ~use_xnor;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            q_m  <= '0;
            n1_q <= '0;
            n0_q <= '0;
            de_q <= 1'b0;
            c1_q <= 1'b0;
            c0_q <= 1'b0;
        end else begin
            q_m  <= q_m_c;
            n1_q <= count_ones(q_m_c[DATA_W-1:0]);
            n0_q <= ONES_W'(DATA_W) - count_ones(q_m_c[DATA_W-1:0]);
            de_q <= de;
            c1_q <= c1;
            c0_q <= c0;
        end
    end

    // Stage 3 combinational: running-disparity balance; blanking emits a token and clears cnt
    always_comb begin
        sym_d    = ctrl_token(c1_q, c0_q);
        cnt_d    = '0;
        cnt_ext  = {cnt[CNT_W-1], cnt};
        bal      = $signed({2'b00, n1_q}) - $signed({2'b00, n0_q});
        cnt_sum  = cnt_ext;
        cnt_zero = (cnt == '0);
        cnt_neg  = cnt[CNT_W-1];
        cnt_pos  = !cnt_neg && !cnt_zero;
        if (de_q) begin
            if (cnt_zero || (n1_q == n0_q)) begin
                sym_d   = {~q_m[QM_W-1], q_m[QM_W-1],
                           q_m[QM_W-1] ? q_m[DATA_W-1:0] : ~q_m[DATA_W-1:0]};
                cnt_sum = q_m[QM_W-1] ? (cnt_ext + bal) : (cnt_ext - bal);
            end else if ((cnt_pos && (n1_q > n0_q)) || (cnt_neg && (n0_q > n1_q))) begin
                sym_d   = {1'b1, q_m[QM_W-1], ~q_m[DATA_W-1:0]};
                cnt_sum = cnt_ext - bal + (q_m[QM_W-1] ? 6'sd2 : 6'sd0);
            end else begin
                sym_d   = {1'b0, q_m[QM_W-1], q_m[DATA_W-1:0]};
                cnt_sum = cnt_ext + bal - (q_m[QM_W-1] ? 6'sd0 : 6'sd2);
            end
            cnt_d = cnt_sum[CNT_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            symbol <= TOKEN_00;
            cnt    <= '0;
        end else begin
            symbol <= sym_d;
            cnt    <= cnt_d;
        end
    end

endmodule

// File: rtl/dvi_tmds_encoder.sv
// DVI TMDS encoder: registers and expands 4-bit pixels, then drives three tmds_channel lanes.
module dvi_tmds_encoder
    import dvi_tmds_encoder_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic [COLOR_W-1:0] video_r,
    input  logic [COLOR_W-1:0] video_g,
    input  logic [COLOR_W-1:0] video_b,
    input  logic               video_de,
    input  logic               video_hsync,
    input  logic               video_vsync,
    output logic [SYM_W-1:0]   tmds_ch0,
    output logic [SYM_W-1:0]   tmds_ch1,
    output logic [SYM_W-1:0]   tmds_ch2
);

    pixel_t s1;

    // Stage 1: capture the pixel and replicate each nibble to full 8-bit range
    always_ff @(posedge clk) begin
        if (reset) begin
            s1 <= '0;
        end else begin
            s1.de    <= video_de;
            s1.hsync <= video_hsync;
            s1.vsync <= video_vsync;
            s1.red   <= {video_r, video_r};
            s1.green <= {video_g, video_g};
            s1.blue  <= {video_b, video_b};
        end
    end

    tmds_channel u_ch0 (
        .clk    (clk),
        .reset  (reset),
        .data   (s1.blue),
        .de     (s1.de),
        .c1     (s1.vsync),
        .c0     (s1.hsync),
        .symbol (tmds_ch0)
    );

    tmds_channel u_ch1 (
        .clk    (clk),
        .reset  (reset),
        .data   (s1.green),
        .de     (s1.de),
        .c1     (1'b0),
        .c0     (1'b0),
        .symbol (tmds_ch1)
    );

    tmds_channel u_ch2 (
        .clk    (clk),
        .reset  (reset),
        .data   (s1.red),
        .de     (s1.de),
        .c1     (1'b0),
        .c0     (1'b0),
        .symbol (tmds_ch2)
    );

endmodule

// File: tb/tb_dvi_tmds_encoder.sv
// Scoreboard bench for dvi_tmds_encoder: spec-level encoder model, decode check and cnt tracking.
module tb_dvi_tmds_encoder;

    logic       clk;
    logic       reset;
    logic [3:0] video_r;
    logic [3:0] video_g;
    logic [3:0] video_b;
    logic       video_de;
    logic       video_hsync;
    logic       video_vsync;
    logic [9:0] tmds_ch0;
    logic [9:0] tmds_ch1;
    logic [9:0] tmds_ch2;

    int checks = 0;
    int errors = 0;
    int mcnt[3];

    typedef struct packed {
        logic [9:0]        s0;
        logic [9:0]        s1;
        logic [9:0]        s2;
        logic signed [4:0] k0;
        logic signed [4:0] k1;
        logic signed [4:0] k2;
        logic              de;
        logic [7:0]        d0;
        logic [7:0]        d1;
        logic [7:0]        d2;
        logic [2:0]        gmask;
        logic [9:0]        g0;
        logic [9:0]        g1;
        logic [9:0]        g2;
    } exp_t;

    exp_t sb[$];

    dvi_tmds_encoder dut (
        .clk         (clk),
        .reset       (reset),
        .video_r     (video_r),
        .video_g     (video_g),
        .video_b     (video_b),
        .video_de    (video_de),
        .video_hsync (video_hsync),
        .video_vsync (video_vsync),
        .tmds_ch0    (tmds_ch0),
        .tmds_ch1    (tmds_ch1),
        .tmds_ch2    (tmds_ch2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // Reference encoder written directly from the DVI algorithm, integer disparity.
    function automatic logic [9:0] model_enc(input int ch, input logic [7:0] d,
                                             input logic de, input logic c1, input logic c0);
        logic [8:0] qm;
        logic [9:0] sym;
        int n1d, n1, n0;
        logic xn;
        if (!de) begin
            mcnt[ch] = 0;
            case ({c1, c0})
                2'b00: return 10'b1101010100;
                2'b01: return 10'b0010101011;
                2'b10: return 10'b0101010100;
                default: return 10'b1010101011;
            endcase
        end
        n1d = $countones(d);
        xn = (n1d > 4) || (n1d == 4 && d[0] == 1'b0);
        qm[0] = d[0];
        for (int i = 1; i < 8; i++)
            qm[i] = xn ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
        qm[8] = ~xn;
        n1 = $countones(qm[7:0]);
        n0 = 8 - n1;
        if (mcnt[ch] == 0 || n1 == n0) begin
            sym = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
            mcnt[ch] += qm[8] ? (n1 - n0) : (n0 - n1);
        end else if ((mcnt[ch] > 0 && n1 > n0) || (mcnt[ch] < 0 && n0 > n1)) begin
            sym = {1'b1, qm[8], ~qm[7:0]};
            mcnt[ch] += (qm[8] ? 2 : 0) + (n0 - n1);
        end else begin
            sym = {1'b0, qm[8], qm[7:0]};
            mcnt[ch] += (n1 - n0) - (qm[8] ? 0 : 2);
        end
        return sym;
    endfunction

    function automatic logic [7:0] decode(input logic [9:0] s);
        logic [7:0] q, d;
        q = s[9] ? ~s[7:0] : s[7:0];
        d[0] = q[0];
        for (int i = 1; i < 8; i++)
            d[i] = s[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
        return d;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic check_cnt(input string tag, input logic [4:0] obs, input logic [4:0] expv);
        int v;
        v = int'($signed(obs));
        check(tag, {27'b0, obs}, {27'b0, expv});
        check({tag, "_range"}, {31'b0, (v >= -10 && v <= 10)}, 32'd1);
    endtask

    function automatic exp_t token_entry();
        exp_t e;
        e = '0;
        e.s0 = 10'h354;
        e.s1 = 10'h354;
        e.s2 = 10'h354;
        return e;
    endfunction

    task automatic compare_out();
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL sb_empty: observed 0 entries expected 1");
            return;
        end
        e = sb.pop_front();
        check("ch0", {22'b0, tmds_ch0}, {22'b0, e.s0});
        check("ch1", {22'b0, tmds_ch1}, {22'b0, e.s1});
        check("ch2", {22'b0, tmds_ch2}, {22'b0, e.s2});
        check_cnt("cnt0", dut.u_ch0.cnt, e.k0);
        check_cnt("cnt1", dut.u_ch1.cnt, e.k1);
        check_cnt("cnt2", dut.u_ch2.cnt, e.k2);
        if (e.de) begin
            check("dec_ch0", {24'b0, decode(tmds_ch0)}, {24'b0, e.d0});
            check("dec_ch1", {24'b0, decode(tmds_ch1)}, {24'b0, e.d1});
            check("dec_ch2", {24'b0, decode(tmds_ch2)}, {24'b0, e.d2});
        end
        if (e.gmask[0]) check("gold_ch0", {22'b0, tmds_ch0}, {22'b0, e.g0});
        if (e.gmask[1]) check("gold_ch1", {22'b0, tmds_ch1}, {22'b0, e.g1});
        if (e.gmask[2]) check("gold_ch2", {22'b0, tmds_ch2}, {22'b0, e.g2});
    endtask

    task automatic step(input logic de, input logic hs, input logic vs,
                        input logic [3:0] r, input logic [3:0] g, input logic [3:0] b,
                        input logic [2:0] gmask = 3'b000, input logic [9:0] g0 = 10'h0,
                        input logic [9:0] g1 = 10'h0, input logic [9:0] g2 = 10'h0);
        exp_t e;
        @(negedge clk);
        reset       = 1'b0;
        video_de    = de;
        video_hsync = hs;
        video_vsync = vs;
        video_r     = r;
        video_g     = g;
        video_b     = b;
        e.s0 = model_enc(0, {b, b}, de, vs, hs);
        e.s1 = model_enc(1, {g, g}, de, 1'b0, 1'b0);
        e.s2 = model_enc(2, {r, r}, de, 1'b0, 1'b0);
        e.k0 = 5'(mcnt[0]);
        e.k1 = 5'(mcnt[1]);
        e.k2 = 5'(mcnt[2]);
        e.de = de;
        e.d0 = {b, b};
        e.d1 = {g, g};
        e.d2 = {r, r};
        e.gmask = gmask;
        e.g0 = g0;
        e.g1 = g1;
        e.g2 = g2;
        sb.push_back(e);
        @(posedge clk);
        #1;
        compare_out();
    endtask

    task automatic rand_pixel();
        step(1'b1, 1'b0, 1'b0, 4'($urandom), 4'($urandom), 4'($urandom));
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            reset    = 1'b1;
            video_de = 1'b1;
            video_r  = 4'($urandom);
            video_g  = 4'($urandom);
            video_b  = 4'($urandom);
            @(posedge clk);
            #1;
            check("rst_ch0", {22'b0, tmds_ch0}, 32'h354);
            check("rst_ch1", {22'b0, tmds_ch1}, 32'h354);
            check("rst_ch2", {22'b0, tmds_ch2}, 32'h354);
            check("rst_cnt0", {27'b0, dut.u_ch0.cnt}, 32'h0);
        end
        sb.delete();
        for (int c = 0; c < 3; c++) mcnt[c] = 0;
        // Two flushed stages still hold reset contents
        sb.push_back(token_entry());
        sb.push_back(token_entry());
    endtask

    initial begin
        reset       = 1'b1;
        video_r     = '0;
        video_g     = '0;
        video_b     = '0;
        video_de    = 1'b0;
        video_hsync = 1'b0;
        video_vsync = 1'b0;

        do_reset(2);
        for (int i = 0; i < 4; i++)
            step(1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 3'b111, 10'h354, 10'h354, 10'h354);

        // Three black blue pixels from cnt=0
        step(1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 3'b001, 10'h100);
        step(1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 3'b001, 10'h3FF);
        step(1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 3'b001, 10'h100);

        // Full red from cnt=0
        step(1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0);
        step(1'b1, 1'b0, 1'b0, 4'hF, 4'h0, 4'h0, 3'b100, 10'h0, 10'h0, 10'h200);

        // Control tokens on ch0
        step(1'b0, 1'b0, 1'b0, 4'h3, 4'h5, 4'h7, 3'b111, 10'h354, 10'h354, 10'h354);
        step(1'b0, 1'b1, 1'b0, 4'h3, 4'h5, 4'h7, 3'b111, 10'h0AB, 10'h354, 10'h354);
        step(1'b0, 1'b0, 1'b1, 4'h3, 4'h5, 4'h7, 3'b111, 10'h154, 10'h354, 10'h354);
        step(1'b0, 1'b1, 1'b1, 4'h3, 4'h5, 4'h7, 3'b111, 10'h2AB, 10'h354, 10'h354);

        // Randomised lines with blanking and sync pulses
        for (int line = 0; line < 2; line++) begin
            for (int px = 0; px < 640; px++) rand_pixel();
            for (int i = 0; i < 16; i++)
                step(1'b0, (i >= 4 && i < 8), (line == 1 && i < 10),
                     4'($urandom), 4'($urandom), 4'($urandom));
        end

        // Reset mid-line, then resume
        for (int px = 0; px < 100; px++) rand_pixel();
        do_reset(1);
        rand_pixel();
        rand_pixel();
        for (int px = 0; px < 40; px++) rand_pixel();
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dvi_tmds_encoder.md
DVI_TMDS_ENCODER -- requirements
Module: dvi_tmds_encoder

Interface
REQ-001 Parameters: none; the encoder SHALL be fixed at 3 channels x 10-bit output.
REQ-002 clk  in  1  video pixel clock; vclk domain; all logic on its rising edge.
REQ-003 reset  in  1  synchronous, active-high reset (vclk-domain synchronised reset).
REQ-004 video_r  in  4  red pixel value from the compositor output registers.
REQ-005 video_g  in  4  green pixel value.
REQ-006 video_b  in  4  blue pixel value.
REQ-007 video_de  in  1  display enable; 1 = active pixel.
REQ-008 video_hsync  in  1  horizontal sync, passed through at the compositor's polarity.
REQ-009 video_vsync  in  1  vertical sync, passed through at the compositor's polarity.
REQ-010 tmds_ch0  out  10  blue channel symbol; bit 0 transmitted first.
REQ-011 tmds_ch1  out  10  green channel symbol.
REQ-012 tmds_ch2  out  10  red channel symbol.

Function
REQ-013 Latency SHALL be exactly 3 clk cycles from any input sample to its symbol on all three channels, with no bubbles and one symbol per clk.
REQ-014 Stage 1 SHALL register the inputs and expand each 4-bit colour to 8 bits as {c,c} (4'hF -> 8'hFF, 4'h0 -> 8'h00), then count N1(D).
REQ-015 Stage 2, transition minimisation: if N1(D)>4, or N1(D)==4 and D[0]==0, then q_m[0]=D[0], q_m[i]=q_m[i-1] XNOR D[i], q_m[8]=0.
REQ-016 Stage 2, otherwise: q_m[i]=q_m[i-1] XOR D[i] and q_m[8]=1; stage 2 SHALL also register N1 and N0 of q_m[7:0].
REQ-017 Stage 3, DC balance, case A (cnt==0 or N1==N0): out={~q_m[8], q_m[8], q_m[8]?q_m[7:0]:~q_m[7:0]}; cnt += q_m[8]?(N1-N0):(N0-N1).
REQ-018 Stage 3, case B ((cnt>0 and N1>N0) or (cnt<0 and N0>N1)): out={1, q_m[8], ~q_m[7:0]}; cnt += 2*q_m[8] + (N0-N1).
REQ-019 Stage 3, case C (else): out={0, q_m[8], q_m[7:0]}; cnt += (N1-N0) - 2*(~q_m[8]).
REQ-020 cnt SHALL be a per-channel 5-bit two's-complement register; its value stays within -10..+10 and it never wraps.
REQ-021 When the stage-3 de is 0, each channel SHALL emit a control token selected by {C1,C0}: 00->10'b1101010100, 01->10'b0010101011, 10->10'b0101010100, 11->10'b1010101011.
REQ-022 During the same blanking cycle, cnt SHALL be cleared to 0.
REQ-023 ch0 SHALL use C0=hsync and C1=vsync; ch1 and ch2 SHALL use C1C0=00.
REQ-024 de, hsync and vsync SHALL be delayed through the pipeline alongside the data, so a de edge switches between token and data on exactly the matching symbol.
REQ-025 On a de 0->1 edge the first data symbol SHALL use cnt=0; on a de 1->0 edge the first blanking symbol SHALL be a token, with no partial symbol in between.

Reset
REQ-026 While reset is 1, all pipeline registers SHALL clear (de=0, hsync=0, vsync=0, data=0) and every cnt SHALL be 0.
REQ-027 From the first clk after reset asserts, all three outputs SHALL read 10'b1101010100.
REQ-028 A reset asserted mid-line SHALL discard in-flight symbols.
REQ-029 After reset deasserts, the first valid symbol SHALL appear 3 cycles after the first sampled input.

Structure
REQ-030 The four control-token constants and the symbol width SHALL live in the shared video package/include.
REQ-031 One sub-module, tmds_channel (8-bit data, de, c1, c0 in; 10-bit symbol out; owns its cnt), SHALL be instantiated three times.
REQ-032 Implementation size: 120-250 lines.

Verification
REQ-033 Reset asserted for 2 cycles -> every channel reads 10'h354 (1101010100) during reset and until valid data arrives.
REQ-034 de=1, b=4'h0 for 3 consecutive pixels -> ch0 emits 10'h100, 10'h3FF, 10'h100; internal cnt goes -8, +2, -6.
REQ-035 de=1, r=4'hF from cnt=0 -> ch2 emits 10'h200 and cnt becomes -8; the symbol appears exactly 3 cycles after input.
REQ-036 de=0 with {vsync,hsync} stepped through 00/01/10/11 -> ch0 emits 354/0AB/154/2AB (hex); ch1 and ch2 stay at 354.
REQ-037 Randomised 640-pixel lines -> a reference-model decode of each symbol equals the expanded input; |cnt| never exceeds 10; cnt reads 0 after every blanking cycle.
REQ-038 Reset pulsed mid-line with de=1 -> the next 3 outputs are 354 on all channels, and encoding resumes correctly from cnt=0.
